key_schedule_generator: RTL and testbench
=========================================

KEY_SCHEDULE_GENERATOR -- requirements
Module: key_schedule_generator

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request a key schedule; sampled only in IDLE.
REQ-004 inverse  input  1  sampled with start; 0 = forward order (0..10), 1 = inverse order (10..0).
REQ-005 cipherKey  input  128 (roundKey_t)  AES-128 cipher key; sampled with start.
REQ-006 roundKey  output  128 (roundKey_t)  current round key, registered.
REQ-007 keyIndex  output  4  round number of roundKey, 0..NUM_ROUNDS.
REQ-008 keyValid  output  1  roundKey/keyIndex valid this cycle; feeds the round stage's valid input.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse the cycle after the last key is presented.

Function
REQ-011 FSM states IDLE, FWD_EMIT, INV_EXPAND, INV_REPLAY; IDLE is the reset state.
REQ-012 IDLE, start=1 at edge E: load key register and buffer[0] with cipherKey, counter=0; go to FWD_EMIT if inverse=0, else INV_EXPAND.
REQ-013 FWD_EMIT: keyValid=1, roundKey=key register, keyIndex=counter; each edge computes next key, writes buffer[counter+1], counter++.
REQ-014 FWD_EMIT: keys 0..10 on cycles E+1..E+11, one per cycle, no gaps; after index 10 go to IDLE.
REQ-015 INV_EXPAND: keyValid=0; 10 edges compute keys 1..10 into buffer[1..10]; then go to INV_REPLAY with counter=10.
REQ-016 INV_REPLAY: keyValid=1, roundKey=buffer[counter], keyIndex=counter; counter-- per edge; keys 10..0 on cycles E+11..E+21; after index 0 go to IDLE.
REQ-017 Next key: w[i]=w[i-4] XOR temp; for the first word temp=SubWord(RotWord(w[i-1])) XOR Rcon[round]; otherwise temp=w[i-1].
REQ-018 Rcon for rounds 1..10 = 01,02,04,08,10,20,40,80,1B,36 in the MSB of the word; round byte word 0 = bits 127:96.
REQ-019 start, inverse and cipherKey ignored while busy=1; no queuing.
REQ-020 done=1 exactly one cycle after the final keyValid cycle; busy=0 that cycle; start in that cycle is accepted.
REQ-021 When keyValid=0, roundKey and keyIndex hold their last values; consumers use keyValid only.
REQ-022 Counter never leaves 0..10; no wrap-around.

Reset
REQ-023 reset=1 at any edge forces IDLE, counter=0, roundKey=0, keyIndex=0, keyValid=0, busy=0, done=0, regardless of state.
REQ-024 Reset mid-schedule aborts with no further keyValid; buffer contents are don't-care after reset.
REQ-025 reset has priority over start at the same edge.

Structure
REQ-026 roundKey_t, NUM_ROUNDS (10), the Rcon table and the FSM state enum live in the shared AES definitions package.
REQ-027 SubWord is one sub-module, sub_word: four S-box lookups, combinational, shared with the existing S-box table.
REQ-028 The 11x128 buffer is a register array written in FWD_EMIT and INV_EXPAND and read in INV_REPLAY.

Verification
REQ-029 Forward, cipherKey 000102030405060708090A0B0C0D0E0F -> index 0 = cipherKey, index 1 = D6AA74FDD2AF72FADAA678F1D6AB76FE, index 10 = 13111D7FE3944A17F307A78B4D2B30C5; 11 consecutive valid cycles.
REQ-030 Inverse, cipherKey 2B7E151628AED2A6ABF7158809CF4F3C -> first valid at E+11 with index 10 = D014F9A8C9EE2589E13F0CC8B6630CA6; last valid at E+21 with index 0 = cipherKey; done at E+22.
REQ-031 start pulsed at E+3 during forward run with a different key -> stream unchanged, no second schedule.
REQ-032 reset asserted at E+5 in INV_EXPAND -> next cycle keyValid=0, busy=0, all outputs 0; a new start then yields the correct schedule.
REQ-033 start held high across done cycle -> second schedule begins with key 0 on the cycle after done; no idle gap beyond that.
REQ-034 Chained with the round stage and inverse round stage: state 00112233445566778899AABBCCDDEEFF, key 000102..0F, over 10 rounds -> ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A; inverse chain restores the plaintext.

Source files
------------

// File: rtl/key_schedule_generator_pkg.sv
// Shared AES-128 definitions for the key schedule generator.
//   roundKey_t  : 128-bit round key, word 0 in bits 127:96
//   NUM_ROUNDS  : number of AES-128 rounds (10)
//   ksg_state_t : key schedule FSM states
//   SBOX / sbox : forward AES S-box table and lookup helper
//   rcon        : round constant byte for rounds 1..10
package key_schedule_generator_pkg;

    typedef logic [127:0] roundKey_t;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        FWD_EMIT,
        INV_EXPAND,
        INV_REPLAY
    } ksg_state_t;

    // Ascending packed range: the leftmost byte is entry 0.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rounds outside 1..10 return 0; the generator never consumes them.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_schedule_generator_sub_word.sv
// sub_word: AES SubWord, four parallel S-box lookups, purely combinational.
//   i_word : 32-bit input word
//   o_word : each byte of i_word substituted through the S-box
module sub_word
    import key_schedule_generator_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_schedule_generator.sv
// key_schedule_generator: AES-128 round key sequencer.
// Emits round keys 0..10 (forward) or 10..0 (inverse) one per cycle.
//   clock     : system clock, rising edge
//   reset     : synchronous active-high reset
//   start     : request a schedule (sampled in IDLE only)
//   inverse   : 0 = forward order, 1 = inverse order (sampled with start)
//   cipherKey : AES-128 cipher key (sampled with start)
//   roundKey  : current round key, registered
//   keyIndex  : round number of roundKey
//   keyValid  : roundKey/keyIndex valid this cycle
//   busy      : FSM not in IDLE
//   done      : one-cycle pulse after the last valid key
module key_schedule_generator
    import key_schedule_generator_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       inverse,
    input  roundKey_t  cipherKey,
    output roundKey_t  roundKey,
    output logic [3:0] keyIndex,
    output logic       keyValid,
    output logic       busy,
    output logic       done
);

    ksg_state_t r_state;
    ksg_state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    roundKey_t  r_key;
    roundKey_t  w_key_nxt;
    roundKey_t  r_roundKey;
    roundKey_t  w_roundKey_nxt;
    logic [3:0] r_keyIndex;
    logic [3:0] w_keyIndex_nxt;
    logic       r_keyValid;
    logic       w_keyValid_nxt;
    logic       r_done;
    logic       w_done_nxt;

    roundKey_t  r_buf [0:NUM_ROUNDS];
    logic       w_buf_we;
    logic [3:0] w_buf_addr;
    roundKey_t  w_buf_data;

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_n0;
    logic [31:0] w_n1;
    logic [31:0] w_n2;
    logic [31:0] w_n3;
    roundKey_t   w_expanded;

    // One expansion round from the working key; r_cnt is the round just held.
    assign w_rot = {r_key[23:0], r_key[31:24]};

    sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_n0       = r_key[127:96] ^ w_sub ^ {rcon(r_cnt + 4'd1), 24'h000000};
    assign w_n1       = r_key[95:64]  ^ w_n0;
    assign w_n2       = r_key[63:32]  ^ w_n1;
    assign w_n3       = r_key[31:0]   ^ w_n2;
    assign w_expanded = {w_n0, w_n1, w_n2, w_n3};

    // Outputs are registered, so each branch loads what the next cycle shows.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_key_nxt      = r_key;
        w_roundKey_nxt = r_roundKey;
        w_keyIndex_nxt = r_keyIndex;
        w_keyValid_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_buf_we       = 1'b0;
        w_buf_addr     = r_cnt + 4'd1;
        w_buf_data     = w_expanded;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_key_nxt  = cipherKey;
                    w_cnt_nxt  = 4'd0;
                    w_buf_we   = 1'b1;
                    w_buf_addr = 4'd0;
                    w_buf_data = cipherKey;
                    if (!inverse) begin
                        w_state_nxt    = FWD_EMIT;
                        w_roundKey_nxt = cipherKey;
                        w_keyIndex_nxt = 4'd0;
                        w_keyValid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = INV_EXPAND;
                    end
                end
            end

            FWD_EMIT: begin
                if (r_cnt == NUM_ROUNDS) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_key_nxt      = w_expanded;
                    w_buf_we       = 1'b1;
                    w_cnt_nxt      = r_cnt + 4'd1;
                    w_roundKey_nxt = w_expanded;
                    w_keyIndex_nxt = r_cnt + 4'd1;
                    w_keyValid_nxt = 1'b1;
                end
            end

            INV_EXPAND: begin
                w_key_nxt = w_expanded;
                w_buf_we  = 1'b1;
                w_cnt_nxt = r_cnt + 4'd1;
                // Last key goes straight to the output; replay reads the buffer from 9 down.
                if (r_cnt == NUM_ROUNDS - 4'd1) begin
                    w_state_nxt    = INV_REPLAY;
                    w_roundKey_nxt = w_expanded;
                    w_keyIndex_nxt = NUM_ROUNDS;
                    w_keyValid_nxt = 1'b1;
                end
            end

            INV_REPLAY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt      = r_cnt - 4'd1;
                    w_roundKey_nxt = r_buf[r_cnt - 4'd1];
                    w_keyIndex_nxt = r_cnt - 4'd1;
                    w_keyValid_nxt = 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_roundKey <= '0;
            r_keyIndex <= 4'd0;
            r_keyValid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_roundKey <= w_roundKey_nxt;
            r_keyIndex <= w_keyIndex_nxt;
            r_keyValid <= w_keyValid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Key datapath carries no reset; contents are irrelevant outside a schedule.
    always_ff @(posedge clock) begin
        r_key <= w_key_nxt;
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= w_buf_data;
        end
    end

    assign roundKey = r_roundKey;
    assign keyIndex = r_keyIndex;
    assign keyValid = r_keyValid;
    assign done     = r_done;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_key_schedule_generator.sv
module tb_key_schedule_generator;

    logic         clock;
    logic         reset;
    logic         start;
    logic         inverse;
    logic [127:0] cipherKey;
    logic [127:0] roundKey;
    logic [3:0]   keyIndex;
    logic         keyValid;
    logic         busy;
    logic         done;

    key_schedule_generator dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .inverse   (inverse),
        .cipherKey (cipherKey),
        .roundKey  (roundKey),
        .keyIndex  (keyIndex),
        .keyValid  (keyValid),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] m_ks   [0:10];
    logic [127:0] obs    [0:10];

    typedef struct {
        logic [127:0] key;
        bit           inv;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv_b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv_b = 8'(y);
            sbox_t[x] = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^ rotl8(inv_b, 3)
                        ^ rotl8(inv_b, 4) ^ 8'h63;
        end
    endtask

    // Textbook word-by-word key expansion over w[0..43].
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge with the DUT idle. Cycle k is the cycle after edge E+k-1.
    task automatic run_schedule(input logic [127:0] key, input bit inv,
                                input int glitch_k, input bit hold);
        int  last;
        bit  exp_valid;
        int  exp_idx;
        int  guard;
        compute_model(key);
        for (int i = 0; i <= 10; i++) obs[i] = 'x;
        last      = inv ? 22 : 12;
        start     = 1'b1;
        inverse   = inv;
        cipherKey = key;
        @(negedge clock);
        if (!hold) begin
            start     = 1'b0;
            inverse   = 1'($urandom);
            cipherKey = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 1; k <= last; k++) begin
            exp_valid = inv ? (k >= 11 && k <= 21) : (k <= 11);
            exp_idx   = inv ? 21 - k : k - 1;
            check("keyValid", 128'(keyValid), 128'(exp_valid));
            check("busy", 128'(busy), 128'(k < last));
            check("done", 128'(done), 128'(k == last));
            if (exp_valid) begin
                check("keyIndex", 128'(keyIndex), 128'(exp_idx));
                check("roundKey", roundKey, m_ks[exp_idx]);
                obs[exp_idx] = roundKey;
            end
            if (k == glitch_k) begin
                start     = 1'b1;
                inverse   = ~inv;
                cipherKey = ~key;
            end else if (!hold) begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        if (hold) begin
            check("hold_restart_valid", 128'(keyValid), 128'(1));
            check("hold_restart_index", 128'(keyIndex), 128'(0));
            check("hold_restart_key", roundKey, key);
            check("hold_restart_busy", 128'(busy), 128'(1));
            start = 1'b0;
            guard = 0;
            while (!done && guard < 40) begin
                @(negedge clock);
                guard++;
            end
            check("hold_second_done", 128'(done), 128'(1));
            @(negedge clock);
        end else begin
            check("idle_after_valid", 128'(keyValid), 128'(0));
            check("idle_after_busy", 128'(busy), 128'(0));
            check("idle_after_done", 128'(done), 128'(0));
        end
    endtask

    vec_t vecs [0:6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        bit           inv;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[6] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1,  128'ha0fafe1788542cb123a339392a6c7605};

        build_sbox();

        reset     = 1'b1;
        start     = 1'b1;
        inverse   = 1'b0;
        cipherKey = '1;
        repeat (3) @(negedge clock);
        check("reset_roundKey", roundKey, 128'h0);
        check("reset_keyIndex", 128'(keyIndex), 128'(0));
        check("reset_keyValid", 128'(keyValid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_busy", 128'(busy), 128'(0));

        // Known-answer vectors.
        for (int i = 0; i < 7; i++) begin
            run_schedule(vecs[i].key, vecs[i].inv, 0, 1'b0);
            check($sformatf("table_%0d", i), obs[vecs[i].idx], vecs[i].exp);
        end

        // start pulsed at E+3 of a forward run with a different key.
        run_schedule(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 3, 1'b0);
        check("glitch_key10", obs[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset at E+5 while expanding for an inverse run.
        start     = 1'b1;
        inverse   = 1'b1;
        cipherKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_keyValid", 128'(keyValid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_roundKey", roundKey, 128'h0);
        check("abort_keyIndex", 128'(keyIndex), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 0, 1'b0);
        check("after_abort_key10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start held across the done cycle: back-to-back schedules.
        run_schedule(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 0, 1'b1);

        // Random keys and directions, with an ignored start while busy.
        for (int r = 0; r < 16; r++) begin
            k   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            run_schedule(k, inv, $urandom_range(1, 10), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
